// File: rtl/bus_rr_host_arbiter.sv
// Round-robin arbiter sharing one device memory port between NrHosts requesters.
// An ID FIFO remembers which host issued each accepted request so responses return in order.
module bus_rr_host_arbiter #(
  parameter int NrHosts        = 3,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrHosts-1:0]             host_req_i,
  output logic [NrHosts-1:0]             host_gnt_o,
  input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]             host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
  input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]             host_rvalid_o,
  output logic [DataWidth-1:0]           host_rdata_o,
  output logic [NrHosts-1:0]             host_err_o,
  output logic                           dev_req_o,
  input  logic                           dev_gnt_i,
  output logic [AddrWidth-1:0]           dev_addr_o,
  output logic                           dev_we_o,
  output logic [DataWidth/8-1:0]         dev_be_o,
  output logic [DataWidth-1:0]           dev_wdata_o,
  input  logic                           dev_rvalid_i,
  input  logic [DataWidth-1:0]           dev_rdata_i,
  input  logic                           dev_err_i,
  output logic                           unexp_rsp_o
);

  localparam int BeWidth = DataWidth / 8;
  localparam int HostW   = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW    = $clog2(MaxOutstanding + 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    ptr_inc = (ptr == PtrW'(MaxOutstanding - 1)) ? {PtrW{1'b0}} : ptr + PtrW'(1);
  endfunction

  logic [HostW-1:0] last_r;
  logic [HostW-1:0] fifo_r [MaxOutstanding];
  logic [PtrW-1:0]  wptr_r;
  logic [PtrW-1:0]  rptr_r;
  logic [CntW-1:0]  count_r;
  logic             unexp_r;

  logic [HostW-1:0] sel_s;
  logic [HostW-1:0] idx_s;
  logic             hit_s;
  logic             sel_valid_s;
  logic             full_s;
  logic             accept_s;
  logic             rsp_s;
  logic [HostW-1:0] head_s;

  // Round-robin search starting just after the last granted host
  always_comb begin
    sel_s       = last_r;
    sel_valid_s = 1'b0;
    idx_s       = last_r;
    hit_s       = 1'b0;
    for (int k = 1; k <= NrHosts; k++) begin
      idx_s       = HostW'((int'(last_r) + k) % NrHosts);
      hit_s       = ~sel_valid_s & host_req_i[idx_s];
      sel_s       = hit_s ? idx_s : sel_s;
      sel_valid_s = sel_valid_s | hit_s;
    end
  end

  // Device request mux, grant and response routing; everything held at zero in reset
  always_comb begin
    full_s        = (count_r == CntW'(MaxOutstanding));
    dev_req_o     = rst_ni & sel_valid_s & ~full_s;
    accept_s      = dev_req_o & dev_gnt_i;
    head_s        = fifo_r[rptr_r];
    rsp_s         = rst_ni & dev_rvalid_i & (count_r != {CntW{1'b0}});
    dev_addr_o    = dev_req_o ? host_addr_i[sel_s*AddrWidth +: AddrWidth] : {AddrWidth{1'b0}};
    dev_we_o      = dev_req_o ? host_we_i[sel_s] : 1'b0;
    dev_be_o      = dev_req_o ? host_be_i[sel_s*BeWidth +: BeWidth] : {BeWidth{1'b0}};
    dev_wdata_o   = dev_req_o ? host_wdata_i[sel_s*DataWidth +: DataWidth] : {DataWidth{1'b0}};
    host_gnt_o    = {NrHosts{1'b0}};
    host_gnt_o[sel_s] = accept_s;
    host_rvalid_o = {NrHosts{1'b0}};
    host_rvalid_o[head_s] = rsp_s;
    host_err_o    = {NrHosts{1'b0}};
    host_err_o[head_s] = rsp_s & dev_err_i;
    host_rdata_o  = rsp_s ? dev_rdata_i : {DataWidth{1'b0}};
  end

  assign unexp_rsp_o = unexp_r;

  // Arbitration history, ID FIFO and sticky unexpected-response flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_r  <= HostW'(NrHosts - 1);
      wptr_r  <= {PtrW{1'b0}};
      rptr_r  <= {PtrW{1'b0}};
      count_r <= {CntW{1'b0}};
      unexp_r <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_r[i] <= {HostW{1'b0}};
      end
    end else begin
      if (accept_s) begin
        fifo_r[wptr_r] <= sel_s;
        wptr_r         <= ptr_inc(wptr_r);
        last_r         <= sel_s;
      end
      if (rsp_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({accept_s, rsp_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
      if (dev_rvalid_i && (count_r == {CntW{1'b0}})) begin
        unexp_r <= 1'b1;
      end
    end
  end

endmodule

// Protocol checker observing the host-side grant and response vectors.
module bus_rr_host_arbiter_chk #(
  parameter int NrHosts        = 3,
  parameter int MaxOutstanding = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic [NrHosts-1:0] gnt,
  input logic [NrHosts-1:0] rvalid
);

  int out_cnt_r;

  // Outstanding transactions as seen from the host side
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_r <= 0;
    end else begin
      out_cnt_r <= out_cnt_r + int'(|gnt) - int'(|rvalid);
    end
  end

  gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt));
  rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid));
  no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !((|gnt) && (out_cnt_r >= MaxOutstanding)));

endmodule

// File: tb/tb_bus_rr_host_arbiter.sv
// Randomized and directed bench for bus_rr_host_arbiter with a queue-based reference
// model; stimulus pushes expected outputs, a monitor pops and compares each cycle.
module tb_bus_rr_host_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      host_req_i;
  logic [N-1:0]      host_gnt_o;
  logic [N*AW-1:0]   host_addr_i;
  logic [N-1:0]      host_we_i;
  logic [N*BW-1:0]   host_be_i;
  logic [N*DW-1:0]   host_wdata_i;
  logic [N-1:0]      host_rvalid_o;
  logic [DW-1:0]     host_rdata_o;
  logic [N-1:0]      host_err_o;
  logic              dev_req_o;
  logic              dev_gnt_i;
  logic [AW-1:0]     dev_addr_o;
  logic              dev_we_o;
  logic [BW-1:0]     dev_be_o;
  logic [DW-1:0]     dev_wdata_o;
  logic              dev_rvalid_i;
  logic [DW-1:0]     dev_rdata_i;
  logic              dev_err_i;
  logic              unexp_rsp_o;

  always #5 clk_i = ~clk_i;

  bus_rr_host_arbiter #(.NrHosts(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o),
    .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
    .unexp_rsp_o(unexp_rsp_o)
  );

  bus_rr_host_arbiter_chk #(.NrHosts(N), .MaxOutstanding(MO)) u_chk (
    .clk_i(clk_i), .rst_ni(rst_ni), .gnt(host_gnt_o), .rvalid(host_rvalid_o)
  );

  typedef struct {
    logic          dev_req;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [N-1:0]  err;
    logic [DW-1:0] rdata;
    logic          unexp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   m_last;
  int   m_out[$];
  bit   m_unexp;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock of stimulus; the reference model predicts this cycle's outputs
  task automatic cycle(input bit rst, input logic [N-1:0] req, input bit gnt,
                       input bit rv, input logic [DW-1:0] rd, input bit er);
    exp_t e;
    int   sel;
    bit   sv;
    int   hd;
    int   h;
    @(negedge clk_i);
    #1;
    rst_ni       = rst;
    host_req_i   = req;
    dev_gnt_i    = gnt;
    dev_rvalid_i = rv;
    dev_rdata_i  = rd;
    dev_err_i    = er;
    for (int i = 0; i < N; i++) begin
      host_addr_i[i*AW +: AW]  = $urandom();
      host_we_i[i]             = 1'($urandom_range(0, 1));
      host_be_i[i*BW +: BW]    = BW'($urandom_range(0, 15));
      host_wdata_i[i*DW +: DW] = $urandom();
    end
    e = '{default: '0};
    if (!rst) begin
      m_last  = N - 1;
      m_out.delete();
      m_unexp = 1'b0;
    end else begin
      e.unexp = m_unexp;
      sv  = 1'b0;
      sel = 0;
      for (int k = 1; k <= N; k++) begin
        h = (m_last + k) % N;
        if (!sv && req[h]) begin
          sv  = 1'b1;
          sel = h;
        end
      end
      e.dev_req = sv && (m_out.size() < MO);
      if (e.dev_req) begin
        e.addr  = host_addr_i[sel*AW +: AW];
        e.we    = host_we_i[sel];
        e.be    = host_be_i[sel*BW +: BW];
        e.wdata = host_wdata_i[sel*DW +: DW];
      end
      if (rv && m_out.size() > 0) begin
        hd          = m_out.pop_front();
        e.rvalid[hd] = 1'b1;
        e.err[hd]    = er;
        e.rdata      = rd;
      end else if (rv) begin
        m_unexp = 1'b1;
      end
      if (e.dev_req && gnt) begin
        e.gnt[sel] = 1'b1;
        m_out.push_back(sel);
        m_last = sel;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest prediction
  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("dev_req", 64'(dev_req_o), 64'(mon_e.dev_req));
        chk("dev_addr", 64'(dev_addr_o), 64'(mon_e.addr));
        chk("dev_we", 64'(dev_we_o), 64'(mon_e.we));
        chk("dev_be", 64'(dev_be_o), 64'(mon_e.be));
        chk("dev_wdata", 64'(dev_wdata_o), 64'(mon_e.wdata));
        chk("host_gnt", 64'(host_gnt_o), 64'(mon_e.gnt));
        chk("host_rvalid", 64'(host_rvalid_o), 64'(mon_e.rvalid));
        chk("host_err", 64'(host_err_o), 64'(mon_e.err));
        chk("host_rdata", 64'(host_rdata_o), 64'(mon_e.rdata));
        chk("unexp_rsp", 64'(unexp_rsp_o), 64'(mon_e.unexp));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; host_req_i = '0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0;
    dev_rdata_i = '0; dev_err_i = 1'b0; host_addr_i = '0; host_we_i = '0;
    host_be_i = '0; host_wdata_i = '0;
    // reset with activity on every input: all outputs must stay zero
    repeat (2) cycle(1'b0, 3'b111, 1'b1, 1'b1, $urandom(), 1'b1);
    // all hosts requesting, response one cycle after each grant
    for (int i = 0; i < 6; i++) cycle(1'b1, 3'b111, 1'b1, i > 0, $urandom(), 1'($urandom_range(0, 1)));
    cycle(1'b1, 3'b000, 1'b0, 1'b1, $urandom(), 1'b0);
    // single host back-to-back
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'b100, 1'b1, i > 0, $urandom(), 1'b0);
    cycle(1'b1, 3'b000, 1'b0, 1'b1, $urandom(), 1'b0);
    // fill to MaxOutstanding, one response, then request reappears
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'b111, 1'b1, 1'b0, $urandom(), 1'b0);
    cycle(1'b1, 3'b111, 1'b1, 1'b1, $urandom(), 1'b0);
    cycle(1'b1, 3'b111, 1'b1, 1'b0, $urandom(), 1'b0);
    repeat (2) cycle(1'b1, 3'b000, 1'b0, 1'b1, $urandom(), 1'b0);
    // ordered routing of data and error
    cycle(1'b0, 3'b000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    cycle(1'b1, 3'b010, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
    cycle(1'b1, 3'b001, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
    cycle(1'b1, 3'b000, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
    cycle(1'b1, 3'b000, 1'b0, 1'b1, 32'h0000_BEEF, 1'b0);
    // response with empty FIFO, sticky flag
    cycle(1'b1, 3'b000, 1'b0, 1'b1, $urandom(), 1'b1);
    repeat (2) cycle(1'b1, 3'b000, 1'b0, 1'b0, $urandom(), 1'b0);
    // reset with two outstanding, then a late response
    cycle(1'b0, 3'b000, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    repeat (2) cycle(1'b1, 3'b111, 1'b1, 1'b0, $urandom(), 1'b0);
    cycle(1'b0, 3'b111, 1'b1, 1'b0, $urandom(), 1'b0);
    cycle(1'b1, 3'b000, 1'b0, 1'b1, $urandom(), 1'b0);
    cycle(1'b1, 3'b111, 1'b1, 1'b0, $urandom(), 1'b0);
    // randomized traffic with occasional resets
    repeat (1500) begin
      cycle($urandom_range(0, 99) != 0, N'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom(), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk_i);
    #5;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
